// File: rtl/ysyx_25060170_mem_arbiter_if.sv
// Signal bundle between the fetch unit, the load/store unit, the shared memory
// port and the arbiter. The arbiter uses the slave view and its environment uses the master view.
interface ysyx_25060170_mem_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_wen;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport slave (
        input  if_req_valid, if_addr, if_flush,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req_valid, if_addr, if_flush,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/ysyx_25060170_mem_arbiter.sv
// Two-requester memory arbiter: load/store has priority over fetch, with a
// starvation limit. It keeps one outstanding transaction and can drop fetch responses on a flush.
module ysyx_25060170_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25060170_mem_arbiter_if.slave    bus
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic             wen_q, wen_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             drop_q, drop_d;
    logic             grant_if, grant_ls;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        starve_d = starve_q;
        drop_d   = drop_q;
        grant_if = 1'b0;
        grant_ls = 1'b0;

        bus.mem_req_valid = 1'b0;
        bus.if_rsp_valid  = 1'b0;
        bus.if_rsp_data   = '0;
        bus.ls_rsp_valid  = 1'b0;
        bus.ls_rsp_data   = '0;

        unique case (state_q)
            S_IDLE: begin
                // Gating with rst keeps the ready outputs low while reset is held.
                grant_if = !rst && bus.if_req_valid &&
                           (!bus.ls_req_valid || starve_q == STARVE_MAX);
                grant_ls = !rst && bus.ls_req_valid && !grant_if;
                if (grant_if) begin
                    owner_d  = OWN_IF;
                    addr_d   = bus.if_addr;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    starve_d = '0;
                    state_d  = S_REQ;
                end else if (grant_ls) begin
                    owner_d = OWN_LS;
                    addr_d  = bus.ls_addr;
                    wen_d   = bus.ls_wen;
                    wdata_d = bus.ls_wdata;
                    wstrb_d = bus.ls_wstrb;
                    if (bus.if_req_valid && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (owner_q == OWN_IF && bus.if_flush) drop_d = 1'b1;
                if (bus.mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (owner_q == OWN_IF && bus.if_flush) drop_d = 1'b1;
                if (bus.mem_rsp_valid) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    if (owner_q == OWN_LS) begin
                        bus.ls_rsp_valid = 1'b1;
                        bus.ls_rsp_data  = bus.mem_rsp_data;
                    end else if (!drop_q && !bus.if_flush) begin
                        bus.if_rsp_valid = 1'b1;
                        bus.if_rsp_data  = bus.mem_rsp_data;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        bus.if_req_ready = grant_if;
        bus.ls_req_ready = grant_ls;
        bus.mem_addr     = addr_q;
        bus.mem_wen      = wen_q;
        bus.mem_wdata    = wdata_q;
        bus.mem_wstrb    = wstrb_q;
    end

endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// Directed bench for the memory arbiter: fetch, conflict, starvation, flush,
// backpressure and mid-transaction reset, with hand-computed expectations.
module tb_ysyx_25060170_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ysyx_25060170_mem_arbiter_if bus ();

    ysyx_25060170_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge. Checks run 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts in REQ. Accepts the request, returns data d one cycle later, and ends in IDLE.
    task automatic complete(input string tag, input logic exp_if, input logic [31:0] d);
        bus.mem_req_ready = 1'b1;
        #1;
        chk({tag, ".mreq_valid"}, {31'b0, bus.mem_req_valid}, 32'd1);
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = d;
        #1;
        chk({tag, ".if_rsp_valid"}, {31'b0, bus.if_rsp_valid}, {31'b0, exp_if});
        chk({tag, ".ls_rsp_valid"}, {31'b0, bus.ls_rsp_valid}, {31'b0, !exp_if});
        chk({tag, ".if_rsp_data"}, bus.if_rsp_data, exp_if ? d : 32'h0);
        chk({tag, ".ls_rsp_data"}, bus.ls_rsp_data, exp_if ? 32'h0 : d);
        chk({tag, ".turnaround"}, {30'b0, bus.if_req_ready, bus.ls_req_ready}, 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    initial begin
        logic exp_is_if [6];
        exp_is_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_0000;
        bus.if_flush      = 1'b0;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = '0;
        bus.ls_wen        = 1'b0;
        bus.ls_wdata      = '0;
        bus.ls_wstrb      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        // While reset is held, all ready and valid outputs must stay low.
        #3;
        chk("rst.if_ready", {31'b0, bus.if_req_ready}, 32'd0);
        chk("rst.ls_ready", {31'b0, bus.ls_req_ready}, 32'd0);
        chk("rst.mreq_valid", {31'b0, bus.mem_req_valid}, 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'h0);
        chk("rst.rsp_valid", {30'b0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'd0);
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single fetch. mem_rsp_valid in REQ must be ignored.
        bus.if_req_valid = 1'b1;
        #1;
        chk("fetch.if_ready", {31'b0, bus.if_req_ready}, 32'd1);
        chk("fetch.ls_ready", {31'b0, bus.ls_req_ready}, 32'd0);
        tick();
        bus.if_req_valid  = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hFFFF_FFFF;
        #1;
        chk("fetch.mem_addr", bus.mem_addr, 32'h8000_0000);
        chk("fetch.mem_wen", {31'b0, bus.mem_wen}, 32'd0);
        chk("fetch.mem_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
        chk("fetch.req_rsp_ignored", {31'b0, bus.if_rsp_valid}, 32'd0);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_0004;
        complete("fetch", 1'b1, 32'h0000_0413);
        #1;
        chk("fetch.rsp_pulse_end", {31'b0, bus.if_rsp_valid}, 32'd0);
        chk("fetch.rsp_data_zero", bus.if_rsp_data, 32'h0);

        // IF and LS request together. LS is granted first, then IF.
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h0000_1000;
        bus.ls_wen       = 1'b1;
        bus.ls_wdata     = 32'hDEAD_BEEF;
        bus.ls_wstrb     = 4'hF;
        #1;
        chk("conf.ls_ready", {31'b0, bus.ls_req_ready}, 32'd1);
        chk("conf.if_ready", {31'b0, bus.if_req_ready}, 32'd0);
        tick();
        bus.ls_req_valid = 1'b0;
        #1;
        chk("conf.mem_addr", bus.mem_addr, 32'h0000_1000);
        chk("conf.mem_wen", {31'b0, bus.mem_wen}, 32'd1);
        chk("conf.mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("conf.mem_wstrb", {28'b0, bus.mem_wstrb}, 32'hF);
        chk("conf.no_grant_req", {30'b0, bus.if_req_ready, bus.ls_req_ready}, 32'd0);
        complete("conf.ls", 1'b0, 32'h0000_0055);
        #1;
        chk("conf.if_next", {31'b0, bus.if_req_ready}, 32'd1);
        tick();
        bus.if_req_valid = 1'b0;
        #1;
        chk("conf.if_addr", bus.mem_addr, 32'h8000_0004);
        chk("conf.if_wen", {31'b0, bus.mem_wen}, 32'd0);
        complete("conf.if", 1'b1, 32'h0000_0013);

        // Both requesters stay valid: expected grant order LS,LS,LS,LS,IF,LS.
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        bus.ls_wen       = 1'b0;
        bus.ls_wstrb     = 4'h0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("starve.grant%0d", i), {30'b0, bus.if_req_ready, bus.ls_req_ready},
                exp_is_if[i] ? 32'd2 : 32'd1);
            tick();
            complete($sformatf("starve.txn%0d", i), exp_is_if[i], 32'h100 + i);
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;

        // A flush in IDLE must not block the grant. A flush in WAIT must drop the response.
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0008;
        bus.if_flush     = 1'b1;
        #1;
        chk("flush.idle_grant", {31'b0, bus.if_req_ready}, 32'd1);
        tick();
        bus.if_req_valid  = 1'b0;
        bus.if_flush      = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.if_flush      = 1'b1;
        tick();
        bus.if_flush      = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1111_1111;
        #1;
        chk("flush.wait_rsp_valid", {31'b0, bus.if_rsp_valid}, 32'd0);
        chk("flush.wait_rsp_data", bus.if_rsp_data, 32'h0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_0014;
        #1;
        chk("flush.back_idle", {31'b0, bus.if_req_ready}, 32'd1);
        tick();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.if_flush      = 1'b1;
        #1;
        chk("flush.same_cycle", {31'b0, bus.if_rsp_valid}, 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.if_flush      = 1'b0;
        bus.if_req_valid  = 1'b1;
        #1;
        tick();
        bus.if_req_valid = 1'b0;
        complete("flush.drop_cleared", 1'b1, 32'h2222_2222);
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h0000_3000;
        bus.if_flush     = 1'b1;
        #1;
        tick();
        bus.ls_req_valid = 1'b0;
        complete("flush.ls_unaffected", 1'b0, 32'h3333_3333);
        bus.if_flush = 1'b0;

        // Memory holds off for 5 cycles. The request must stay stable and no new grant may occur.
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h0000_2000;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_000C;
        #1;
        chk("bp.ls_grant", {31'b0, bus.ls_req_ready}, 32'd1);
        tick();
        bus.ls_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp.valid%0d", i), {31'b0, bus.mem_req_valid}, 32'd1);
            chk($sformatf("bp.addr%0d", i), bus.mem_addr, 32'h0000_2000);
            chk($sformatf("bp.no_grant%0d", i), {30'b0, bus.if_req_ready, bus.ls_req_ready}, 32'd0);
            tick();
        end
        complete("bp", 1'b0, 32'hCAFE_F00D);
        bus.if_req_valid = 1'b0;

        // Reset in WAIT. Outputs drop at once and a late response is ignored.
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0020;
        #1;
        tick();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.ls_req_valid  = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0BAD;
        rst = 1'b1;
        #1;
        chk("rstw.mreq_valid", {31'b0, bus.mem_req_valid}, 32'd0);
        chk("rstw.readies", {30'b0, bus.if_req_ready, bus.ls_req_ready}, 32'd0);
        chk("rstw.rsp_valid", {30'b0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'd0);
        tick();
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("rstw.late_rsp%0d", i), {30'b0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'd0);
            tick();
        end
        bus.mem_rsp_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_mem_arbiter.md
YSYX_25060170_MEM_ARBITER -- requirements
Module: ysyx_25060170_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive LS grants while IF waits.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port if_req_valid  in  1  fetch request.
REQ-005 SHALL have port if_req_ready  out  1  fetch request accepted.
REQ-006 SHALL have port if_addr  in  32  fetch address.
REQ-007 SHALL have port if_flush  in  1  discard any outstanding fetch response.
REQ-008 SHALL have port if_rsp_valid  out  1  fetch data valid, 1-cycle pulse.
REQ-009 SHALL have port if_rsp_data  out  32  fetched instruction.
REQ-010 SHALL have port ls_req_valid  in  1  load/store request.
REQ-011 SHALL have port ls_req_ready  out  1  load/store request accepted.
REQ-012 SHALL have ports ls_addr  in  32; ls_wen  in  1; ls_wdata  in  32; ls_wstrb  in  4  (access address, 1 = store, store data, byte strobes).
REQ-013 SHALL have port ls_rsp_valid  out  1  load data / store done, 1-cycle pulse.
REQ-014 SHALL have port ls_rsp_data  out  32  load data.
REQ-015 SHALL have ports mem_req_valid  out  1; mem_req_ready  in  1  memory request handshake.
REQ-016 SHALL have ports mem_addr  out  32; mem_wen  out  1; mem_wdata  out  32; mem_wstrb  out  4.
REQ-017 SHALL have ports mem_rsp_valid  in  1; mem_rsp_data  in  32  memory response.

Function
REQ-018 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE, one outstanding transaction max.
REQ-019 IDLE: SHALL grant one requester combinationally; granted *_req_ready = 1, other = 0; both 0 if no request.
REQ-020 Grant priority SHALL be LS over IF, except IF wins when both valid and starve counter == STARVE_LIMIT.
REQ-021 Starve counter SHALL increment (saturating at STARVE_LIMIT) on each LS grant with if_req_valid = 1, clear on every IF grant.
REQ-022 On grant handshake SHALL register owner, addr, wen, wdata, wstrb (IF: wen = 0, wdata = 0, wstrb = 0) and enter REQ next cycle.
REQ-023 REQ: mem_req_valid SHALL be 1 with registered fields stable; on mem_req_ready = 1 enter WAIT.
REQ-024 WAIT: on mem_rsp_valid = 1, SHALL pulse owner's *_rsp_valid in the same cycle, *_rsp_data = mem_rsp_data, and return to IDLE.
REQ-025 Turnaround SHALL be one cycle: no *_req_ready in the cycle a response is delivered, so minimum request-to-request spacing is 3 cycles.
REQ-026 if_flush = 1 while owner = IF in REQ or WAIT SHALL set drop flag; the transaction completes on the memory side, but if_rsp_valid is suppressed.
REQ-027 if_flush in the same cycle as a delivering mem_rsp_valid (owner IF) SHALL suppress that if_rsp_valid.
REQ-028 if_flush SHALL NOT affect LS-owned transactions or IDLE arbitration; drop flag clears on return to IDLE.
REQ-029 mem_rsp_valid SHALL be ignored in IDLE and REQ.
REQ-030 Non-owner *_rsp_valid SHALL be 0; *_rsp_data SHALL be 0 when corresponding *_rsp_valid = 0.
REQ-031 mem_req_valid SHALL be 0 outside REQ; mem_* fields are don't-care when invalid.

Reset
REQ-032 rst = 1 SHALL immediately force IDLE, starve counter 0, drop flag 0, owner IF, all registered fields 0, all valid/ready outputs 0.
REQ-033 Reset mid-transaction SHALL abandon it; no rsp_valid is emitted for it after reset release.

Verification
REQ-034 Fetch: if_req_valid, if_addr = 0x80000000, mem_req_ready at cycle 1, mem_rsp_valid with 0x00000413 two cycles later -> one if_rsp_valid pulse, data 0x00000413.
REQ-035 Conflict: IF and LS valid in the same IDLE cycle, ls_wen = 1, ls_wstrb = 0xF -> LS granted first, mem_wen = 1; IF granted next IDLE.
REQ-036 Starvation: both requesting continuously, STARVE_LIMIT = 4 -> grant order LS,LS,LS,LS,IF,LS...
REQ-037 Flush: if_flush pulse in WAIT of a fetch -> mem response consumed, if_rsp_valid stays 0, FSM back in IDLE.
REQ-038 Backpressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_addr stable throughout, no new grant.
REQ-039 Reset: rst asserted during WAIT -> outputs 0 immediately; a late mem_rsp_valid produces no rsp pulse.
